// File: rtl/swervolf_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_rst_pkg
// Brief    : Shared definitions for the SweRVolf reset sequencer: reset cause
//            encodings, sequencer state type and cause selection helper.
// Revision : 1.0 - initial release
// ============================================================================
package swervolf_rst_pkg;

    localparam logic [1:0] RST_CAUSE_POR = 2'd0;
    localparam logic [1:0] RST_CAUSE_BTN = 2'd1;
    localparam logic [1:0] RST_CAUSE_SW  = 2'd2;
    localparam logic [1:0] RST_CAUSE_DBG = 2'd3;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } rst_state_t;

    // Debug wins over the button, the button wins over software.
    function automatic logic [1:0] rst_cause_sel(input logic dbg,
                                                 input logic btn,
                                                 input logic sw);
        logic [1:0] cause;
        cause = RST_CAUSE_SW;
        if (dbg) begin
            cause = RST_CAUSE_DBG;
        end else if (btn) begin
            cause = RST_CAUSE_BTN;
        end else if (sw) begin
            cause = RST_CAUSE_SW;
        end
        return cause;
    endfunction

endpackage
`default_nettype wire

// File: rtl/swervolf_debounce.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_debounce
// Brief    : Two-flop synchroniser followed by a stability counter. The output
//            follows the synchronised input only after CYCLES consecutive
//            samples that differ from the current output.
// Revision : 1.0 - initial release
// ============================================================================
module swervolf_debounce
    import swervolf_rst_pkg::*;
#(
    parameter int   CYCLES    = 250000,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    localparam int                CNT_W    = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    // Count consecutive differing samples; any agreeing sample restarts the
    // count, so the counter never climbs past CNT_LAST.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            level_q <= RESET_VAL;
            cnt_q   <= '0;
        end else if (sync_q[1] == level_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign dout = level_q;

endmodule
`default_nettype wire

// File: rtl/swervolf_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_rst_seq
// Brief    : SweRVolf system reset sequencer. Merges power-on, button,
//            software and debug resets, stretches the result to a minimum
//            width and records the cause and number of resets.
// Revision : 1.0 - initial release
// ============================================================================
module swervolf_rst_seq
    import swervolf_rst_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_btn_rst_n,
    input  logic       i_sw_rst,
    input  logic       i_dbg_rst,
    output logic       o_rst,
    output logic [1:0] o_rst_cause,
    output logic [7:0] o_rst_count
);

    localparam int               HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        rst_sync_q;
    logic              rst_sync;
    logic              btn_n_db;
    logic              trig;

    rst_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              rst_q, rst_d;
    logic [1:0]        cause_q, cause_d;
    logic [7:0]        count_q, count_d;

    // Release of rstn is synchronised; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync = rst_sync_q[1];

    swervolf_debounce #(
        .CYCLES    (DEBOUNCE_CYCLES),
        .RESET_VAL (1'b1)
    ) u_btn_debounce (
        .clk  (clk),
        .rstn (rstn),
        .din  (i_btn_rst_n),
        .dout (btn_n_db)
    );

    assign trig = ~btn_n_db | i_sw_rst | i_dbg_rst;

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            rst_q   <= 1'b1;
            cause_q <= RST_CAUSE_POR;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            rst_q   <= rst_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: HOLD stretches the reset until triggers have been
    // quiet for HOLD_CYCLES edges; RUN latches cause and count on a trigger.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rst_d   = rst_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            ST_HOLD: begin
                rst_d = 1'b1;
                if (!rst_sync || trig) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    rst_d   = 1'b0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                rst_d = 1'b0;
                if (trig) begin
                    state_d = ST_HOLD;
                    rst_d   = 1'b1;
                    hold_d  = '0;
                    cause_d = rst_cause_sel(i_dbg_rst, ~btn_n_db, i_sw_rst);
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_HOLD;
                rst_d   = 1'b1;
                hold_d  = '0;
            end
        endcase
    end

    assign o_rst       = rst_q;
    assign o_rst_cause = cause_q;
    assign o_rst_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_swervolf_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_swervolf_rst_seq
// Brief    : Directed self-checking bench for swervolf_rst_seq with
//            DEBOUNCE_CYCLES=8 and HOLD_CYCLES=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swervolf_rst_seq;

    logic       clk;
    logic       rstn;
    logic       i_btn_rst_n;
    logic       i_sw_rst;
    logic       i_dbg_rst;
    logic       o_rst;
    logic [1:0] o_rst_cause;
    logic [7:0] o_rst_count;

    int n_checks;
    int n_fail;

    swervolf_rst_seq #(
        .DEBOUNCE_CYCLES (8),
        .HOLD_CYCLES     (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_btn_rst_n (i_btn_rst_n),
        .i_sw_rst    (i_sw_rst),
        .i_dbg_rst   (i_dbg_rst),
        .o_rst       (o_rst),
        .o_rst_cause (o_rst_cause),
        .o_rst_count (o_rst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Release rstn mid-cycle; o_rst must fall on edge 2+HOLD_CYCLES = 6.
    task automatic por_sequence(input string tag);
        rstn = 1'b1;
        tick(5);
        check_eq({tag, "_rst_edge5"}, o_rst, 1);
        tick(1);
        check_eq({tag, "_rst_edge6"}, o_rst, 0);
        check_eq({tag, "_cause"}, o_rst_cause, 0);
        check_eq({tag, "_count"}, o_rst_count, 0);
    endtask

    int saw_rst;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rstn        = 1'b0;
        i_btn_rst_n = 1'b1;
        i_sw_rst    = 1'b0;
        i_dbg_rst   = 1'b0;

        // Reset state while rstn is held low.
        tick(3);
        check_eq("reset_rst", o_rst, 1);
        check_eq("reset_cause", o_rst_cause, 0);
        check_eq("reset_count", o_rst_count, 0);

        por_sequence("por");

        // Software reset: one-cycle pulse sampled at edge N.
        i_sw_rst = 1'b1;
        tick(1);
        check_eq("sw_rst_N", o_rst, 1);
        check_eq("sw_cause", o_rst_cause, 2);
        check_eq("sw_count", o_rst_count, 1);
        i_sw_rst = 1'b0;
        tick(3);
        check_eq("sw_rst_N3", o_rst, 1);
        tick(1);
        check_eq("sw_rst_N4", o_rst, 0);

        // Bouncing button: toggles every 3 cycles, never stable for 8.
        saw_rst = 0;
        for (int i = 0; i < 10; i++) begin
            i_btn_rst_n = ~i_btn_rst_n;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                if (o_rst) saw_rst = 1;
            end
        end
        tick(4);
        if (o_rst) saw_rst = 1;
        check_eq("bounce_no_rst", saw_rst, 0);

        // Stable press held for 12 cycles: 2 sync + 8 debounce edges, then
        // the FSM samples trig on the following edge.
        i_btn_rst_n = 1'b0;
        tick(10);
        check_eq("btn_rst_k10", o_rst, 0);
        tick(1);
        check_eq("btn_rst_k11", o_rst, 1);
        check_eq("btn_cause", o_rst_cause, 1);
        check_eq("btn_count", o_rst_count, 2);
        tick(1);
        i_btn_rst_n = 1'b1;
        // Release debounced high after edge k+22, reset ends 4 edges later.
        tick(13);
        check_eq("btn_hold_k25", o_rst, 1);
        tick(1);
        check_eq("btn_end_k26", o_rst, 0);
        check_eq("btn_count_once", o_rst_count, 2);

        // Simultaneous software and debug: debug wins, one count.
        i_sw_rst  = 1'b1;
        i_dbg_rst = 1'b1;
        tick(1);
        check_eq("sim_rst", o_rst, 1);
        check_eq("sim_cause", o_rst_cause, 3);
        check_eq("sim_count", o_rst_count, 3);
        i_sw_rst  = 1'b0;
        i_dbg_rst = 1'b0;
        tick(1);
        i_sw_rst = 1'b1;
        tick(1);
        i_sw_rst = 1'b0;
        check_eq("ext_cause", o_rst_cause, 3);
        check_eq("ext_count", o_rst_count, 3);
        tick(3);
        check_eq("ext_rst_hold", o_rst, 1);
        tick(1);
        check_eq("ext_rst_end", o_rst, 0);

        // Count saturation: 3 + 260 resets clamps at 255.
        for (int i = 0; i < 260; i++) begin
            i_sw_rst = 1'b1;
            tick(1);
            i_sw_rst = 1'b0;
            tick(4);
        end
        check_eq("sat_count", o_rst_count, 255);
        check_eq("sat_cause", o_rst_cause, 2);
        check_eq("sat_run", o_rst, 0);

        // rstn dropped in the middle of a HOLD sequence.
        i_sw_rst = 1'b1;
        tick(1);
        i_sw_rst = 1'b0;
        tick(1);
        rstn = 1'b0;
        #1;
        check_eq("midhold_rst", o_rst, 1);
        check_eq("midhold_cause", o_rst_cause, 0);
        check_eq("midhold_count", o_rst_count, 0);
        tick(2);
        por_sequence("por2");

        // rstn dropped while a button press is being debounced.
        i_btn_rst_n = 1'b0;
        tick(5);
        check_eq("middb_pre", o_rst, 0);
        rstn = 1'b0;
        #1;
        check_eq("middb_rst_async", o_rst, 1);
        check_eq("middb_cause", o_rst_cause, 0);
        i_btn_rst_n = 1'b1;
        tick(2);
        por_sequence("por3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
